// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: releases one rover UART command sender at a time, muxes its line out, re-sends the last command as a heartbeat; define MOTOR_CMD_DEDUP_EN to drop repeated identical requests
module motor_cmd_sequencer #(
  parameter int GAP_CYCLES       = 50_000,
  parameter int HEARTBEAT_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES   = 5_000_000,
  parameter int READY_MASK       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid_i,
  input  logic [1:0] cmd_code_i,
  input  logic [2:0] speed_in_i,
  output logic       cmd_ready_o,
  output logic [3:0] sender_rst_o,
  input  logic [3:0] sender_ready_i,
  input  logic [3:0] sender_uart_i,
  output logic       uart_out_o,
  output logic [2:0] speed_out_o,
  output logic       busy_o,
  output logic       timeout_err_o
);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int HW = $clog2(HEARTBEAT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int MW = $clog2(READY_MASK) + 1;
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES - 1);
  localparam logic [HW-1:0] HB_MAX   = HW'(HEARTBEAT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [MW-1:0] MASK_MAX = MW'(READY_MASK - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d, last_cmd_q, last_cmd_d;
  logic [2:0]    speed_q, speed_d;
  logic          last_valid_q, last_valid_d, timeout_q, timeout_d;
  logic [3:0]    sender_rst_q, sender_rst_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [HW-1:0] hb_q, hb_d;
  logic [TW-1:0] to_q, to_d;
  logic [MW-1:0] mask_q, mask_d;
  logic          accept, dup, launch, hb_exp;
  logic [3:0]    sel_oh;
  logic [TW-1:0] to_inc;

`ifdef MOTOR_CMD_DEDUP_EN
  assign dup = last_valid_q && cmd_code_i == last_cmd_q && speed_in_i == speed_q;
`else
  assign dup = 1'b0;
`endif

  assign accept = cmd_valid_i && cmd_ready_o;
  assign launch = accept && !dup;
  assign hb_exp = last_valid_q && hb_q == HB_MAX;
  assign sel_oh = 4'b0001 << sel_q;
  assign to_inc = to_q == TO_MAX ? to_q : to_q + 1'b1;

  // state and datapath registers; reset returns every sender to reset and the line to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_cmd_q   <= '0;
      speed_q      <= '0;
      last_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      sender_rst_q <= 4'hF;
      gap_q        <= '0;
      hb_q         <= '0;
      to_q         <= '0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_cmd_q   <= last_cmd_d;
      speed_q      <= speed_d;
      last_valid_q <= last_valid_d;
      timeout_q    <= timeout_d;
      sender_rst_q <= sender_rst_d;
      gap_q        <= gap_d;
      hb_q         <= hb_d;
      to_q         <= to_d;
      mask_q       <= mask_d;
    end
  end

  // next state: counters idle at zero outside their own state and saturate inside it
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_cmd_d   = last_cmd_q;
    speed_d      = speed_q;
    last_valid_d = last_valid_q;
    timeout_d    = timeout_q;
    sender_rst_d = 4'hF;
    gap_d        = '0;
    hb_d         = '0;
    to_d         = '0;
    mask_d       = '0;
    case (state_q)
      IDLE: begin
        hb_d = (last_valid_q && !launch) ? (hb_exp ? hb_q : hb_q + 1'b1) : '0;
        if (launch) begin
          state_d      = LAUNCH;
          sel_d        = cmd_code_i;
          last_cmd_d   = cmd_code_i;
          speed_d      = speed_in_i;
          last_valid_d = 1'b1;
        end else if (hb_exp) begin
          state_d = LAUNCH;
          sel_d   = last_cmd_q;
        end
      end
      LAUNCH: begin
        mask_d       = mask_q == MASK_MAX ? mask_q : mask_q + 1'b1;
        to_d         = to_inc;
        sender_rst_d = ~sel_oh;
        state_d      = mask_q == MASK_MAX ? SEND : LAUNCH;
      end
      SEND: begin
        to_d = to_inc;
        if (sender_ready_i[sel_q]) begin
          state_d = GAP;
        end else if (to_q == TO_MAX) begin
          state_d   = GAP;
          timeout_d = 1'b1;
        end else begin
          sender_rst_d = ~sel_oh;
        end
      end
      GAP: begin
        gap_d   = gap_q == GAP_MAX ? gap_q : gap_q + 1'b1;
        state_d = gap_q == GAP_MAX ? IDLE : GAP;
      end
    endcase
  end

  // outputs decoded from registered state so the uart mux select never glitches
  always_comb begin
    cmd_ready_o   = state_q == IDLE && !rst;
    busy_o        = state_q != IDLE;
    uart_out_o    = (state_q == LAUNCH || state_q == SEND) ? sender_uart_i[sel_q] : 1'b1;
    sender_rst_o  = sender_rst_q;
    speed_out_o   = speed_q;
    timeout_err_o = timeout_q;
  end
endmodule
